// File: rtl/sram_pkg.sv
// Shared types and sizing for the SRAM DMA engine.
package sram_pkg;

  localparam int SRAM_DEPTH  = 2048;
  localparam int SRAM_ADDR_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    RD,
    WR,
    DONE
  } dma_state_t;

  typedef enum logic {
    MODE_COPY = 1'b0,
    MODE_FILL = 1'b1
  } dma_mode_t;

endpackage

// File: rtl/sram_dma_engine_if.sv
// SRAM access bus between the DMA engine (master) and the memory (slave).
interface sram_dma_engine_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
);

  logic              sram_req;
  logic              sram_we;
  logic [3:0]        sram_be;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;
  logic              sram_ready;

  modport master (
    output sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    input  sram_rdata, sram_ready
  );

  modport slave (
    input  sram_req, sram_we, sram_be, sram_addr, sram_wdata,
    output sram_rdata, sram_ready
  );

endinterface

// File: rtl/sram_dma_engine.sv
// Word-granular SRAM copy/fill DMA engine with bounds checking.
// Define SRAM_DMA_CHECKSUM_EN to enable the running checksum of written words.
module sram_dma_engine
  import sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [11:0]         len_words,
  input  logic [31:0]         fill_data,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [31:0]         checksum,
  sram_dma_engine_if.master   bus
);

  // Wide enough that address + length*4 never wraps, even for len_words > 2048.
  localparam int EW = ((ADDR_W > 14) ? ADDR_W : 14) + 2;

  dma_state_t        state_reg, state_next;
  dma_mode_t         mode_reg;
  logic [ADDR_W-1:0] src_ptr_reg, dst_ptr_reg;
  logic [11:0]       cnt_reg;
  logic [31:0]       hold_reg, fill_reg;
  logic              err_reg;

  logic              accept, set_err, rd_cap, wr_adv, cfg_err;
  logic [31:0]       wr_word;
  logic [EW-1:0]     span, src_end, dst_end, limit;

  always_comb begin
    span    = EW'({cnt_reg, 2'b00});
    src_end = EW'(src_ptr_reg) + span;
    dst_end = EW'(dst_ptr_reg) + span;
    limit   = EW'(1) << ADDR_W;
    cfg_err = (dst_ptr_reg[1:0] != 2'b00) || (dst_end > limit);
    if (mode_reg == MODE_COPY) begin
      cfg_err = cfg_err || (src_ptr_reg[1:0] != 2'b00) || (src_end > limit);
    end
  end

  assign wr_word = (mode_reg == MODE_COPY) ? hold_reg : fill_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    accept         = 1'b0;
    set_err        = 1'b0;
    rd_cap         = 1'b0;
    wr_adv         = 1'b0;
    bus.sram_req   = 1'b0;
    bus.sram_we    = 1'b0;
    bus.sram_be    = 4'h0;
    bus.sram_addr  = '0;
    bus.sram_wdata = 32'h0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = CHECK;
        end
      end
      CHECK: begin
        if (abort) begin
          state_next = IDLE;
        end else if (cfg_err) begin
          set_err    = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == 12'd0) begin
          state_next = DONE;
        end else begin
          state_next = (mode_reg == MODE_COPY) ? RD : WR;
        end
      end
      RD: begin
        bus.sram_req  = 1'b1;
        bus.sram_be   = 4'hF;
        bus.sram_addr = src_ptr_reg;
        rd_cap        = bus.sram_ready;
        if (abort) begin
          state_next = IDLE;
        end else if (bus.sram_ready) begin
          state_next = WR;
        end
      end
      WR: begin
        bus.sram_req   = 1'b1;
        bus.sram_we    = 1'b1;
        bus.sram_be    = 4'hF;
        bus.sram_addr  = dst_ptr_reg;
        bus.sram_wdata = wr_word;
        // A write completing on the abort cycle still counts; only the FSM stops.
        wr_adv         = bus.sram_ready;
        if (abort) begin
          state_next = IDLE;
        end else if (bus.sram_ready) begin
          if (cnt_reg == 12'd1) begin
            state_next = DONE;
          end else begin
            state_next = (mode_reg == MODE_COPY) ? RD : WR;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr_reg <= '0;
      dst_ptr_reg <= '0;
      cnt_reg     <= 12'd0;
      hold_reg    <= 32'h0;
      fill_reg    <= 32'h0;
      mode_reg    <= MODE_COPY;
      err_reg     <= 1'b0;
    end else begin
      if (accept) begin
        src_ptr_reg <= src_addr;
        dst_ptr_reg <= dst_addr;
        cnt_reg     <= len_words;
        fill_reg    <= fill_data;
        mode_reg    <= dma_mode_t'(mode);
        err_reg     <= 1'b0;
      end
      if (set_err) begin
        err_reg <= 1'b1;
      end
      if (rd_cap) begin
        hold_reg <= bus.sram_rdata;
      end
      if (wr_adv) begin
        src_ptr_reg <= src_ptr_reg + ADDR_W'(4);
        dst_ptr_reg <= dst_ptr_reg + ADDR_W'(4);
        cnt_reg     <= cnt_reg - 12'd1;
      end
    end
  end

`ifdef SRAM_DMA_CHECKSUM_EN
  logic [31:0] csum_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_reg <= 32'h0;
    end else if (accept) begin
      csum_reg <= 32'h0;
    end else if (wr_adv) begin
      csum_reg <= csum_reg + wr_word;
    end
  end

  assign checksum = csum_reg;
`else
  assign checksum = 32'h0;
`endif

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign err  = err_reg;

endmodule

// File: doc/sram_dma_engine.md
SRAM_DMA_ENGINE -- requirements
Module: sram_dma_engine

Interface
REQ-001 Parameter ADDR_W SHALL be: ADDR_W, 13, SRAM byte-address width (8 KB).
REQ-002 The clock and reset ports SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  block clock; all logic rising-edge.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 start  in  1  one-cycle pulse launching a transfer; sampled only in IDLE.
REQ-006 mode  in  1  0=copy, 1=fill.
REQ-007 src_addr  in  ADDR_W  copy source byte address.
REQ-008 dst_addr  in  ADDR_W  destination byte address.
REQ-009 len_words  in  12  transfer length in 32-bit words, 0..2048.
REQ-010 fill_data  in  32  pattern written in fill mode.
REQ-011 abort  in  1  terminates the active transfer.
REQ-012 busy  out  1  high from the cycle after accepted start until return to IDLE.
REQ-013 done  out  1  one-cycle pulse on successful completion.
REQ-014 err  out  1  sticky error flag; cleared by next accepted start.
REQ-015 checksum  out  32  running word sum (see Configuration).
REQ-016 sram_req, sram_we  out  1 each  SRAM access request and write enable.
REQ-017 sram_be  out  4; sram_addr  out  ADDR_W; sram_wdata  out  32  access byte mask, byte address, write data.
REQ-018 sram_rdata  in  32; sram_ready  in  1  combinational read data and access-complete strobe.

Function
REQ-019 FSM states SHALL be IDLE, CHECK, RD, WR, DONE; start in IDLE moves to CHECK and latches all config inputs.
REQ-020 CHECK SHALL set err and return to IDLE (no SRAM access, no done) if src/dst bits[1:0]!=0 or addr+len_words*4 > 2^ADDR_W (src checked in copy mode only; arithmetic 14-bit, no wrap).
REQ-021 CHECK with len_words=0 and no error SHALL go to DONE with no SRAM access.
REQ-022 Otherwise CHECK SHALL go to RD (copy) or WR (fill).
REQ-023 RD SHALL drive req=1, we=0, be=4'hF, addr=src pointer; when sram_ready, capture sram_rdata into a hold register and go to WR.
REQ-024 WR SHALL drive req=1, we=1, be=4'hF, addr=dst pointer, wdata=hold (copy) or fill_data (fill); advance on sram_ready.
REQ-025 On an advancing WR, both pointers SHALL increment by 4 and the remaining count decrement by 1; count reaching 0 goes to DONE, else RD (copy) or stays WR (fill).
REQ-026 While sram_ready=0 in RD or WR, all SRAM outputs SHALL hold stable.
REQ-027 Throughput SHALL be 2 cycles/word in copy and 1 cycle/word in fill with sram_ready=1.
REQ-028 DONE SHALL pulse done for exactly one cycle and return to IDLE.
REQ-029 Copy SHALL always proceed in ascending address order; overlapping regions get no special handling.
REQ-030 abort in CHECK/RD/WR SHALL drop sram_req the next cycle and return to IDLE without done; an access already completing in that cycle completes.
REQ-031 start while not in IDLE SHALL be ignored; sram_req SHALL be 0 in IDLE, CHECK and DONE.

Reset
REQ-032 rst SHALL force IDLE and all outputs to 0 (sram_be=4'h0, checksum=0), and clear pointers, count and hold register; rst mid-transfer aborts with no done.

Configuration
REQ-033 With SRAM_DMA_CHECKSUM_EN defined, checksum SHALL clear on accepted start and add (mod 2^32) each word written on every advancing WR.
REQ-034 Without SRAM_DMA_CHECKSUM_EN, checksum SHALL be tied to 32'h0 and no adder SHALL be synthesised.

Structure
REQ-035 Package sram_pkg SHALL hold SRAM_DEPTH=2048, SRAM_ADDR_W=13, the dma_state_t enum and the dma_mode_t enum.
REQ-036 The block SHALL be a single module with no sub-module.

Verification
REQ-037 Fill: dst=0x100, len=4, fill_data=0xA5A5A5A5 -> 4 consecutive write cycles at 0x100..0x10C, done 1 cycle after the last write, checksum=0x96969694.
REQ-038 Copy: src=0x000 pre-loaded 0x11,0x22,0x33; dst=0x200, len=3 -> 6 access cycles, 0x200..0x208 hold the same words, checksum=0x66.
REQ-039 Error: dst=0x1FFC, len=2 fill -> err=1, no sram_req, no done; src=0x002 copy -> err=1.
REQ-040 len=0 -> done pulses 2 cycles after start, sram_req never asserts.
REQ-041 Stall/abort: sram_ready held low for 3 cycles in WR -> outputs stable; abort in the 3rd word of len=8 -> req low next cycle, busy low, no done.
